// File: rtl/reg_bank_sequencer.sv
// rtl/reg_bank_sequencer.sv - two-requester sequencer driving FunSel/I/E of a 16-bit register bank
// Optional FIXED_PRIORITY_EN: A always wins a simultaneous request; no round-robin pointer.
module reg_bank_sequencer #(
  parameter int SEL_W = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  A_Valid,
  input  logic [3:0]            A_Op,
  input  logic [SEL_W-1:0]      A_Sel,
  input  logic [15:0]           A_Data,
  output logic                  A_Ready,
  input  logic                  B_Valid,
  input  logic [3:0]            B_Op,
  input  logic [SEL_W-1:0]      B_Sel,
  input  logic [15:0]           B_Data,
  output logic                  B_Ready,
  output logic [2:0]            FunSel,
  output logic [15:0]           I,
  output logic [(2**SEL_W)-1:0] E,
  output logic                  Busy
);

  localparam int NUM_REGS = 2**SEL_W;

  localparam logic [2:0] FS_LOAD_LO = 3'b100;
  localparam logic [2:0] FS_LOAD_HI = 3'b110;

  typedef enum logic [1:0] {IDLE, ISSUE, SPLIT_LO, SPLIT_HI} state_t;

  state_t               state, state_next;
  logic [7:0]           hi_q, hi_next;
  logic [SEL_W-1:0]     sel_q, sel_next;
  logic [2:0]           fs_next;
  logic [15:0]          i_next;
  logic [NUM_REGS-1:0]  e_next;
  logic                 can_accept, grant_a, grant_b, accept;
  logic [3:0]           op;
  logic [SEL_W-1:0]     sel;
  logic [15:0]          data;
`ifndef FIXED_PRIORITY_EN
  logic                 rr_b, rr_b_next;
`endif

  // SPLIT_LO is the only cycle whose next-cycle controls are already committed
  always_comb begin
    can_accept = !Reset && (state != SPLIT_LO);
`ifdef FIXED_PRIORITY_EN
    grant_a    = can_accept && A_Valid;
`else
    grant_a    = can_accept && A_Valid && (!B_Valid || !rr_b);
`endif
    grant_b    = can_accept && B_Valid && !grant_a;
    accept     = grant_a || grant_b;
    op         = grant_a ? A_Op   : B_Op;
    sel        = grant_a ? A_Sel  : B_Sel;
    data       = grant_a ? A_Data : B_Data;
  end

  assign A_Ready = grant_a;
  assign B_Ready = grant_b;

  always_comb begin
    state_next = IDLE;
    fs_next    = FunSel;
    i_next     = I;
    e_next     = '0;
    hi_next    = hi_q;
    sel_next   = sel_q;
    if (accept) begin
      sel_next     = sel;
      e_next[sel]  = 1'b1;
      if (op[3]) begin
        state_next = SPLIT_LO;
        fs_next    = FS_LOAD_LO;
        i_next     = {8'h00, data[7:0]};
        hi_next    = data[15:8];
      end else begin
        state_next = ISSUE;
        fs_next    = op[2:0];
        i_next     = data;
      end
    end else if (state == SPLIT_LO) begin
      state_next    = SPLIT_HI;
      fs_next       = FS_LOAD_HI;
      i_next        = {8'h00, hi_q};
      e_next[sel_q] = 1'b1;
    end
  end

`ifndef FIXED_PRIORITY_EN
  always_comb begin
    rr_b_next = rr_b;
    if (grant_a) rr_b_next = 1'b1;
    else if (grant_b) rr_b_next = 1'b0;
  end
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= IDLE;
      FunSel <= 3'b000;
      I      <= 16'h0000;
      E      <= '0;
      Busy   <= 1'b0;
      hi_q   <= 8'h00;
      sel_q  <= '0;
`ifndef FIXED_PRIORITY_EN
      rr_b   <= 1'b0;
`endif
    end else begin
      state  <= state_next;
      FunSel <= fs_next;
      I      <= i_next;
      E      <= e_next;
      Busy   <= (state_next != IDLE);
      hi_q   <= hi_next;
      sel_q  <= sel_next;
`ifndef FIXED_PRIORITY_EN
      rr_b   <= rr_b_next;
`endif
    end
  end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// tb/tb_reg_bank_sequencer.sv - vector-table bench for reg_bank_sequencer with a register-bank model
module tb_reg_bank_sequencer;

`ifdef FIXED_PRIORITY_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic        Clock, Reset;
  logic        A_Valid, B_Valid, A_Ready, B_Ready;
  logic [3:0]  A_Op, B_Op;
  logic [1:0]  A_Sel, B_Sel;
  logic [15:0] A_Data, B_Data;
  logic [2:0]  FunSel;
  logic [15:0] I;
  logic [3:0]  E;
  logic        Busy;

  reg_bank_sequencer #(.SEL_W(2)) dut (
    .Clock(Clock), .Reset(Reset),
    .A_Valid(A_Valid), .A_Op(A_Op), .A_Sel(A_Sel), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Op(B_Op), .B_Sel(B_Sel), .B_Data(B_Data), .B_Ready(B_Ready),
    .FunSel(FunSel), .I(I), .E(E), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Register bank model, updated from the controls present during each cycle
  logic [15:0] regs [4];
  initial for (int k = 0; k < 4; k++) regs[k] = 16'h0000;

  function automatic logic [15:0] apply_fs(input logic [2:0] fs, input logic [15:0] r, input logic [15:0] d);
    case (fs)
      3'b000:  return r - 16'd1;
      3'b001:  return r + 16'd1;
      3'b010:  return d;
      3'b011:  return 16'h0000;
      3'b100:  return {8'h00, d[7:0]};
      3'b101:  return {r[15:8], d[7:0]};
      3'b110:  return {d[7:0], r[7:0]};
      default: return {{8{d[7]}}, d[7:0]};
    endcase
  endfunction

  always @(posedge Clock)
    for (int k = 0; k < 4; k++)
      if (E[k] === 1'b1) regs[k] <= apply_fs(FunSel, regs[k], I);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        av; logic [3:0] aop; logic [1:0] asel; logic [15:0] ad;
    logic        bv; logic [3:0] bop; logic [1:0] bsel; logic [15:0] bd;
    logic        ar, br;
    logic [3:0]  e; logic [2:0] fs; logic [15:0] i; logic busy;
  } vec_t;

  function automatic vec_t mk(
    input logic rst,
    input logic av, input logic [3:0] aop, input logic [1:0] asel, input logic [15:0] ad,
    input logic bv, input logic [3:0] bop, input logic [1:0] bsel, input logic [15:0] bd,
    input logic ar, input logic br,
    input logic [3:0] e, input logic [2:0] fs, input logic [15:0] i, input logic busy);
    vec_t v;
    v.rst = rst;
    v.av = av; v.aop = aop; v.asel = asel; v.ad = ad;
    v.bv = bv; v.bop = bop; v.bsel = bsel; v.bd = bd;
    v.ar = ar; v.br = br; v.e = e; v.fs = fs; v.i = i; v.busy = busy;
    return v;
  endfunction

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    Reset = 1'b1;
    A_Valid = 0; A_Op = 0; A_Sel = 0; A_Data = 0;
    B_Valid = 0; B_Op = 0; B_Sel = 0; B_Data = 0;

    // reset, then single load from A
    vecs[0]  = mk(1, 0,4'b0000,0,16'h0000, 0,4'b0000,0,16'h0000, 0,0, 4'b0000,3'b000,16'h0000,0);
    vecs[1]  = mk(0, 1,4'b0010,2,16'h1234, 0,4'b0000,0,16'h0000, 1,0, 4'b0100,3'b010,16'h1234,1);
    vecs[2]  = mk(0, 0,4'b0000,0,16'h0000, 0,4'b0000,0,16'h0000, 0,0, 4'b0000,3'b010,16'h1234,0);
    // B split load; A waits through SPLIT_LO and is taken in SPLIT_HI
    vecs[3]  = mk(0, 0,4'b0000,0,16'h0000, 1,4'b1000,1,16'hABCD, 0,1, 4'b0010,3'b100,16'h00CD,1);
    vecs[4]  = mk(0, 1,4'b0010,0,16'h5555, 0,4'b0000,0,16'h0000, 0,0, 4'b0010,3'b110,16'h00AB,1);
    vecs[5]  = mk(0, 1,4'b0010,0,16'h5555, 0,4'b0000,0,16'h0000, 1,0, 4'b0001,3'b010,16'h5555,1);
    vecs[6]  = mk(0, 0,4'b0000,0,16'h0000, 0,4'b0000,0,16'h0000, 0,0, 4'b0000,3'b010,16'h5555,0);
    // both requesters held valid from reset
    vecs[7]  = mk(1, 1,4'b0010,0,16'h1111, 1,4'b0010,3,16'h2222, 0,0, 4'b0000,3'b000,16'h0000,0);
    vecs[8]  = mk(0, 1,4'b0010,0,16'h1111, 1,4'b0010,3,16'h2222, 1,0, 4'b0001,3'b010,16'h1111,1);
    vecs[9]  = mk(0, 1,4'b0010,0,16'h1111, 1,4'b0010,3,16'h2222, FP,!FP,
                  FP ? 4'b0001 : 4'b1000, 3'b010, FP ? 16'h1111 : 16'h2222, 1);
    vecs[10] = mk(0, 1,4'b0010,0,16'h1111, 1,4'b0010,3,16'h2222, 1,0, 4'b0001,3'b010,16'h1111,1);
    vecs[11] = vecs[9];
    vecs[12] = mk(0, 0,4'b0000,0,16'h0000, 0,4'b0000,0,16'h0000, 0,0,
                  4'b0000,3'b010, FP ? 16'h1111 : 16'h2222, 0);
    // three back-to-back increments of R3
    vecs[13] = mk(0, 1,4'b0001,3,16'hFFFF, 0,4'b0000,0,16'h0000, 1,0, 4'b1000,3'b001,16'hFFFF,1);
    vecs[14] = vecs[13];
    vecs[15] = vecs[13];
    vecs[16] = mk(0, 0,4'b0000,0,16'h0000, 0,4'b0000,0,16'h0000, 0,0, 4'b0000,3'b001,16'hFFFF,0);
    // split with nonzero Op[2:0], which must be ignored
    vecs[17] = mk(0, 1,4'b1111,2,16'h7E81, 0,4'b0000,0,16'h0000, 1,0, 4'b0100,3'b100,16'h0081,1);
    vecs[18] = mk(0, 0,4'b0000,0,16'h0000, 0,4'b0000,0,16'h0000, 0,0, 4'b0100,3'b110,16'h007E,1);
    vecs[19] = mk(0, 0,4'b0000,0,16'h0000, 0,4'b0000,0,16'h0000, 0,0, 4'b0000,3'b110,16'h007E,0);

    for (int n = 0; n < NV; n++) begin
      @(negedge Clock);
      Reset = vecs[n].rst;
      A_Valid = vecs[n].av; A_Op = vecs[n].aop; A_Sel = vecs[n].asel; A_Data = vecs[n].ad;
      B_Valid = vecs[n].bv; B_Op = vecs[n].bop; B_Sel = vecs[n].bsel; B_Data = vecs[n].bd;
      #1;
      chk($sformatf("v%0d A_Ready", n), {15'd0, A_Ready}, {15'd0, vecs[n].ar});
      chk($sformatf("v%0d B_Ready", n), {15'd0, B_Ready}, {15'd0, vecs[n].br});
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d E", n),      {12'd0, E},      {12'd0, vecs[n].e});
      chk($sformatf("v%0d FunSel", n), {13'd0, FunSel}, {13'd0, vecs[n].fs});
      chk($sformatf("v%0d I", n),      I,               vecs[n].i);
      chk($sformatf("v%0d Busy", n),   {15'd0, Busy},   {15'd0, vecs[n].busy});
      if (n == 6) begin
        chk("reg R1 after split", regs[1], 16'hABCD);
        chk("reg R0 after load",  regs[0], 16'h5555);
        chk("reg R2 after load",  regs[2], 16'h1234);
      end
      if (n == 16) chk("reg R3 after 3 inc", regs[3], FP ? 16'h0003 : 16'h2225);
      if (n == 19) chk("reg R2 after split", regs[2], 16'h7E81);
    end

    // reset during SPLIT_LO aborts the high-byte write
    @(negedge Clock);
    Reset = 0;
    A_Valid = 1; A_Op = 4'b1000; A_Sel = 1; A_Data = 16'h9A3C;
    #1 chk("abort accept A_Ready", {15'd0, A_Ready}, 16'd1);
    @(posedge Clock);
    #1;
    chk("abort lo FunSel", {13'd0, FunSel}, 16'h0004);
    chk("abort lo E",      {12'd0, E},      16'h0002);
    chk("abort lo I",      I,               16'h003C);
    @(negedge Clock);
    A_Valid = 0;
    Reset = 1;
    #1 chk("abort A_Ready in reset", {15'd0, A_Ready}, 16'd0);
    @(posedge Clock);
    #1;
    chk("abort E",      {12'd0, E},      16'h0000);
    chk("abort Busy",   {15'd0, Busy},   16'h0000);
    chk("abort FunSel", {13'd0, FunSel}, 16'h0000);
    @(negedge Clock);
    Reset = 0;
    @(posedge Clock);
    #1;
    chk("abort no hi write", {15'd0, (FunSel == 3'b110) && (E != 4'b0000)}, 16'd0);
    chk("abort post E",      {12'd0, E}, 16'h0000);
    chk("reg R1 low kept",   regs[1], 16'h003C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
